// File: rtl/align_lock_if.sv
// Handshake bundle between the per-channel bit aligner, this lock controller and the pixel framer.
// The slave modport is the controller's view; the master modport drives the aligner-side inputs.
interface align_lock_if #(
  parameter int DATA_WIDTH = 24
);
  logic                  train_req;
  logic [DATA_WIDTH-1:0] din;
  logic                  align_done_in;
  logic [4:0]            shift_in;
  logic                  align_start;
  logic                  busy;
  logic                  locked;
  logic                  fail;
  logic [4:0]            lock_shift;
  logic [3:0]            retry_cnt;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  data_valid;

  modport slave (
    input  train_req, din, align_done_in, shift_in,
    output align_start, busy, locked, fail, lock_shift, retry_cnt, data_out, data_valid
  );

  modport master (
    output train_req, din, align_done_in, shift_in,
    input  align_start, busy, locked, fail, lock_shift, retry_cnt, data_out, data_valid
  );
endinterface

// File: rtl/align_lock_ctrl.sv
// Training sequencer and lock monitor downstream of the bit aligner: arms the aligner, waits,
// counts consecutive clean training words, retries on error and forwards data once locked.
module align_lock_ctrl #(
  parameter int                    DATA_WIDTH    = 24,
  parameter logic [DATA_WIDTH-1:0] PATTERN_1     = 24'hFFF000,
  parameter logic [DATA_WIDTH-1:0] PATTERN_2     = 24'hFF0000,
  parameter int                    ARM_CYCLES    = 2,
  parameter int                    SETTLE_CYCLES = 4,
  parameter int                    LOCK_COUNT    = 16,
  parameter int                    MAX_RETRY     = 8
) (
  input  logic         clk,
  input  logic         data_rst,
  align_lock_if.slave  bus
);

  typedef enum logic [2:0] {IDLE, ARM, SETTLE, CHECK, LOCKED, FAIL} state_t;

  state_t                state;
  logic [3:0]            phase_cnt;
  logic [7:0]            match_cnt;
  logic [3:0]            retry_cnt;
  logic                  align_start;
  logic                  busy;
  logic                  locked;
  logic                  fail;
  logic [4:0]            lock_shift;
  logic [DATA_WIDTH-1:0] data_p1;
  logic                  vld_p1;

  logic                  match;
  logic [7:0]            match_next;
  logic [3:0]            retry_next;

  function automatic logic [3:0] sat_inc4(input logic [3:0] v);
    return (v == 4'hF) ? v : v + 4'd1;
  endfunction

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  // A word only counts when the aligner itself also reports a pattern match.
  assign match      = bus.align_done_in && ((bus.din == PATTERN_1) || (bus.din == PATTERN_2));
  assign match_next = sat_inc8(match_cnt);
  assign retry_next = sat_inc4(retry_cnt);

  always_ff @(posedge clk or posedge data_rst) begin
    if (data_rst) begin
      state       <= IDLE;
      phase_cnt   <= '0;
      match_cnt   <= '0;
      retry_cnt   <= '0;
      align_start <= 1'b0;
      busy        <= 1'b0;
      locked      <= 1'b0;
      fail        <= 1'b0;
      lock_shift  <= '0;
      data_p1     <= '0;
      vld_p1      <= 1'b0;
    end else begin
      vld_p1 <= 1'b0;
      case (state)
        IDLE, LOCKED, FAIL: begin
          if (bus.train_req) begin
            state       <= ARM;
            phase_cnt   <= '0;
            match_cnt   <= '0;
            retry_cnt   <= '0;
            lock_shift  <= '0;
            locked      <= 1'b0;
            fail        <= 1'b0;
            align_start <= 1'b1;
            busy        <= 1'b1;
          end else if (state == LOCKED) begin
            // Output stage: forward the aligned word while lock holds.
            data_p1 <= bus.din;
            vld_p1  <= 1'b1;
          end
        end
        ARM: begin
          if (phase_cnt == 4'(ARM_CYCLES - 1)) begin
            state       <= SETTLE;
            phase_cnt   <= '0;
            align_start <= 1'b0;
          end else begin
            phase_cnt <= sat_inc4(phase_cnt);
          end
        end
        SETTLE: begin
          if (phase_cnt == 4'(SETTLE_CYCLES - 1)) begin
            state     <= CHECK;
            phase_cnt <= '0;
            match_cnt <= '0;
          end else begin
            phase_cnt <= sat_inc4(phase_cnt);
          end
        end
        CHECK: begin
          if (match) begin
            match_cnt <= match_next;
            if (match_next == 8'(LOCK_COUNT)) begin
              state      <= LOCKED;
              locked     <= 1'b1;
              busy       <= 1'b0;
              lock_shift <= bus.shift_in;
            end
          end else begin
            retry_cnt <= retry_next;
            if (retry_next == 4'(MAX_RETRY)) begin
              state <= FAIL;
              fail  <= 1'b1;
              busy  <= 1'b0;
            end else begin
              state       <= ARM;
              phase_cnt   <= '0;
              align_start <= 1'b1;
            end
          end
        end
        default: begin
          state       <= IDLE;
          align_start <= 1'b0;
          busy        <= 1'b0;
        end
      endcase
    end
  end

  assign bus.align_start = align_start;
  assign bus.busy        = busy;
  assign bus.locked      = locked;
  assign bus.fail        = fail;
  assign bus.lock_shift  = lock_shift;
  assign bus.retry_cnt   = retry_cnt;
  assign bus.data_out    = data_p1;
  assign bus.data_valid  = vld_p1;

endmodule

// File: tb/tb_align_lock_ctrl.sv
// Bench for align_lock_ctrl: table of training scenarios scored through a queue of expected
// outcomes, plus hand-written restart and mid-training reset sequences.
module tb_align_lock_ctrl;
  localparam int          DW = 24;
  localparam logic [23:0] P1 = 24'hFFF000;
  localparam logic [23:0] P2 = 24'hFF0000;

  logic clk = 1'b0;
  logic data_rst;
  always #5 clk = ~clk;

  align_lock_if #(.DATA_WIDTH(DW)) bus();

  align_lock_ctrl #(
    .DATA_WIDTH(DW), .PATTERN_1(P1), .PATTERN_2(P2), .ARM_CYCLES(2),
    .SETTLE_CYCLES(4), .LOCK_COUNT(16), .MAX_RETRY(8)
  ) dut (
    .clk(clk),
    .data_rst(data_rst),
    .bus(bus.slave)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [23:0] din;
    logic        done;
    logic [4:0]  shift;
    int          corrupt_edge;
    int          poke_edge;
    logic        exp_locked;
    logic        exp_fail;
    logic [3:0]  exp_retry;
    int          exp_edges;
    int          exp_bursts;
  } vec_t;

  typedef struct {
    logic       locked;
    logic       fail;
    logic [3:0] retry;
    logic [4:0] shift;
    int         edges;
    int         bursts;
  } exp_t;

  exp_t sb[$];
  vec_t vecs[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    data_rst          = 1'b1;
    bus.train_req     = 1'b0;
    bus.din           = '0;
    bus.align_done_in = 1'b0;
    bus.shift_in      = '0;
    @(negedge clk);
    @(negedge clk);
    data_rst = 1'b0;
  endtask

  // Edge 1 is the edge that samples train_req; returns the edge at which locked or fail rose.
  task automatic run_train(input vec_t v, output int edges, output int bursts, output int hi);
    logic prev;
    prev              = 1'b0;
    edges             = 0;
    bursts            = 0;
    hi                = 0;
    bus.din           = v.din;
    bus.align_done_in = v.done;
    bus.shift_in      = v.shift;
    @(negedge clk);
    bus.train_req = 1'b1;
    for (int e = 1; e <= 300; e++) begin
      @(posedge clk);
      #1;
      bus.train_req = (e + 1 == v.poke_edge);
      bus.din       = (e + 1 == v.corrupt_edge) ? (v.din ^ 24'h000001) : v.din;
      if (bus.align_start) begin
        hi++;
        if (!prev) bursts++;
      end
      prev = bus.align_start;
      if (bus.locked || bus.fail) begin
        edges = e;
        break;
      end
    end
    if (edges == 0) $display("FAIL timeout: no lock or fail within 300 edges");
  endtask

  initial begin
    int   edges, bursts, hi;
    exp_t ex;

    //            din        done shift  corrupt poke lock fail retry edges bursts
    vecs[0] = '{P1,          1'b1, 5'h07, 0,  0,  1'b1, 1'b0, 4'd0, 23, 1};
    vecs[1] = '{24'h123456,  1'b1, 5'h03, 0,  0,  1'b0, 1'b1, 4'd8, 57, 8};
    vecs[2] = '{P2,          1'b1, 5'h1F, 18, 0,  1'b1, 1'b0, 4'd1, 40, 2}; // 11th check word corrupt
    vecs[3] = '{P1,          1'b0, 5'h05, 0,  0,  1'b0, 1'b1, 4'd8, 57, 8};
    vecs[4] = '{P2,          1'b1, 5'h10, 0,  0,  1'b1, 1'b0, 4'd0, 23, 1};
    vecs[5] = '{24'hFFF001,  1'b1, 5'h02, 0,  0,  1'b0, 1'b1, 4'd8, 57, 8};
    vecs[6] = '{P1,          1'b1, 5'h0A, 0,  12, 1'b1, 1'b0, 4'd0, 23, 1}; // train_req mid-CHECK

    do_reset();
    #1;
    chk("rst_align_start", 32'(bus.align_start), 32'd0);
    chk("rst_busy",        32'(bus.busy),        32'd0);
    chk("rst_locked",      32'(bus.locked),      32'd0);
    chk("rst_fail",        32'(bus.fail),        32'd0);
    chk("rst_retry",       32'(bus.retry_cnt),   32'd0);
    chk("rst_valid",       32'(bus.data_valid),  32'd0);
    chk("rst_data_out",    32'(bus.data_out),    32'd0);

    for (int i = 0; i < 7; i++) begin
      do_reset();
      sb.push_back('{vecs[i].exp_locked, vecs[i].exp_fail, vecs[i].exp_retry,
                     vecs[i].exp_locked ? vecs[i].shift : 5'h00,
                     vecs[i].exp_edges, vecs[i].exp_bursts});
      run_train(vecs[i], edges, bursts, hi);
      ex = sb.pop_front();
      chk($sformatf("v%0d_locked", i),     32'(bus.locked),     32'(ex.locked));
      chk($sformatf("v%0d_fail", i),       32'(bus.fail),       32'(ex.fail));
      chk($sformatf("v%0d_retry", i),      32'(bus.retry_cnt),  32'(ex.retry));
      chk($sformatf("v%0d_lock_shift", i), 32'(bus.lock_shift), 32'(ex.shift));
      chk($sformatf("v%0d_edges", i),      32'(edges),          32'(ex.edges));
      chk($sformatf("v%0d_bursts", i),     32'(bursts),         32'(ex.bursts));
      chk($sformatf("v%0d_arm_cycles", i), 32'(hi),             32'(ex.bursts * 2));
      chk($sformatf("v%0d_busy", i),       32'(bus.busy),       32'd0);
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_data_valid", i), 32'(bus.data_valid), 32'(ex.locked));
      if (ex.locked) chk($sformatf("v%0d_data_out", i), 32'(bus.data_out), 32'(vecs[i].din));
    end

    // Retrain from LOCKED: lock and valid drop on the sampling edge, then relock 23 edges in.
    do_reset();
    run_train(vecs[0], edges, bursts, hi);
    @(negedge clk);
    bus.shift_in  = 5'h0C;
    bus.train_req = 1'b1;
    @(posedge clk);
    #1;
    bus.train_req = 1'b0;
    chk("relock_locked_drop", 32'(bus.locked),      32'd0);
    chk("relock_valid_drop",  32'(bus.data_valid),  32'd0);
    chk("relock_busy",        32'(bus.busy),        32'd1);
    chk("relock_align_start", 32'(bus.align_start), 32'd1);
    chk("relock_shift_clear", 32'(bus.lock_shift),  32'd0);
    edges = 0;
    for (int e = 2; e <= 60; e++) begin
      @(posedge clk);
      #1;
      if (bus.locked) begin
        edges = e;
        break;
      end
    end
    chk("relock_edges", 32'(edges),          32'd23);
    chk("relock_shift", 32'(bus.lock_shift), 32'h0C);

    // Restart from FAIL clears fail/retry at the sampling edge; then reset in the second SETTLE.
    do_reset();
    run_train(vecs[1], edges, bursts, hi);
    @(negedge clk);
    bus.train_req = 1'b1;
    @(posedge clk);
    #1;
    bus.train_req = 1'b0;
    chk("restart_fail_clear",  32'(bus.fail),      32'd0);
    chk("restart_retry_clear", 32'(bus.retry_cnt), 32'd0);
    chk("restart_busy",        32'(bus.busy),      32'd1);
    for (int e = 2; e <= 12; e++) begin
      @(posedge clk);
    end
    #1;
    chk("pre_rst_retry", 32'(bus.retry_cnt), 32'd1);
    chk("pre_rst_busy",  32'(bus.busy),      32'd1);
    data_rst = 1'b1;
    #1;
    chk("async_rst_align_start", 32'(bus.align_start), 32'd0);
    chk("async_rst_busy",        32'(bus.busy),        32'd0);
    chk("async_rst_locked",      32'(bus.locked),      32'd0);
    chk("async_rst_retry",       32'(bus.retry_cnt),   32'd0);
    @(negedge clk);
    data_rst          = 1'b0;
    bus.din           = P1;
    bus.align_done_in = 1'b1;
    for (int e = 0; e < 5; e++) begin
      @(posedge clk);
      #1;
      chk($sformatf("idle_busy_%0d", e),  32'(bus.busy),        32'd0);
      chk($sformatf("idle_start_%0d", e), 32'(bus.align_start), 32'd0);
    end
    run_train(vecs[4], edges, bursts, hi);
    chk("post_rst_edges",  32'(edges),      32'd23);
    chk("post_rst_locked", 32'(bus.locked), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/align_lock_ctrl.md
Name: align_lock_ctrl

Overview:
Training sequencer and lock monitor that sits directly downstream of the per-channel bit aligner in the TI-ROIC receive path. It pulses the aligner's align_start and consumes the aligned word, align_done and applied shift. It declares lock only after a run of consecutive clean training words, retrying a bounded number of times before flagging failure. Once locked, it forwards aligned data to the pixel framer with a valid qualifier.

Parameters:
DATA_WIDTH, 24, width of aligned word
PATTERN_1, 24'hFFF000, first training pattern
PATTERN_2, 24'hFF0000, second training pattern
ARM_CYCLES, 2, cycles align_start is held high per attempt (1..15)
SETTLE_CYCLES, 4, wait after align_start drops before checking (1..15)
LOCK_COUNT, 16, consecutive matching words required for lock (1..255)
MAX_RETRY, 8, attempts before FAIL (1..15)

Ports:
clk  in  1  word clock
data_rst  in  1  asynchronous active-high reset
train_req  in  1  start/restart training; level sampled per clock
din  in  DATA_WIDTH  aligned word from bit aligner
align_done_in  in  1  aligner pattern-match status
shift_in  in  5  aligner applied shift
align_start  out  1  enable to aligner (registered)
busy  out  1  high in ARM/SETTLE/CHECK
locked  out  1  lock achieved
fail  out  1  retries exhausted
lock_shift  out  5  shift_in captured at lock
retry_cnt  out  4  attempts consumed in current training
data_out  out  DATA_WIDTH  registered din, forwarded only when locked
data_valid  out  1  qualifies data_out

Behaviour:
- Interface: reset data_rst, asynchronous, active-high; clock clk. All outputs registered; all reset to 0; FSM resets to IDLE.
- States: IDLE, ARM, SETTLE, CHECK, LOCKED, FAIL.
- IDLE/LOCKED/FAIL + train_req=1: next state ARM; locked, fail, retry_cnt, lock_shift and match counter clear at the same edge.
- ARM: align_start=1 for exactly ARM_CYCLES cycles, then SETTLE. align_start is 0 in every other state.
- SETTLE: SETTLE_CYCLES cycles, then CHECK with match counter = 0.
- CHECK: per cycle, match = align_done_in && (din==PATTERN_1 || din==PATTERN_2).
  - match: counter increments; on reaching LOCK_COUNT, go to LOCKED and capture lock_shift <= shift_in at that edge.
  - mismatch: retry_cnt increments. If the new value equals MAX_RETRY, go to FAIL. Otherwise go to ARM.
- Lock latency with clean data: locked rises 1+ARM_CYCLES+SETTLE_CYCLES+LOCK_COUNT edges after train_req is first sampled high. Defaults give 23.
- train_req while busy is ignored; no restart.
- LOCKED: data_out <= din and data_valid=1 every cycle. Outside LOCKED, data_valid=0 and data_out holds its last value.
- FAIL: fail=1 and held until train_req or reset. retry_cnt holds MAX_RETRY.
- busy=1 exactly in ARM, SETTLE and CHECK.
- Counters saturate and never wrap. Reset mid-training returns immediately to IDLE with all outputs at 0.

Test Plan:
- Clean PATTERN_1 stream, shift_in=5'h07, 1-cycle train_req → align_start high 2 cycles; locked=1 exactly 23 edges after train_req; lock_shift=7; retry_cnt=0; data_valid=1 next cycle.
- din=24'h123456 constant → 8 ARM bursts (align_start high 2 cycles each); fail=1 with retry_cnt=8; locked=0; busy=0.
- PATTERN_2 with one corrupt word at CHECK cycle 10 of the first attempt → retry_cnt=1, second ARM burst; locked at 23+1+2+4+10=40 edges after train_req (first attempt's CHECK ends at edge 17, re-check starts at edge 24, lock at edge 40).
- align_done_in=0 while din=PATTERN_1 → treated as mismatch; fail after 8 attempts.
- train_req pulsed during CHECK → ignored, lock timing unchanged. train_req pulsed in LOCKED → locked and data_valid drop next edge, training restarts.
- data_rst asserted mid-SETTLE → align_start, busy, locked, retry_cnt all 0 asynchronously; after release, state is IDLE until train_req.
